// File: rtl/add_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add_driver: issues operand beats to an adder and checks the results. |
// | Optional cycle counter: ADD_DRIVER_CYCLE_COUNT_EN.  Rev 1.0          |
// +----------------------------------------------------------------------+
module add_driver #(
  parameter int LANES   = 1,
  parameter int MAX_OUT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           num,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [32*LANES-1:0]   op_a,
  output logic [32*LANES-1:0]   op_b,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [32*LANES-1:0]   res_y,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_count,
  output logic [31:0]           cycles
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;
  localparam logic [3:0] c_max_out  = 4'(MAX_OUT);

  logic [1:0]  r_state;
  logic [15:0] r_num;
  logic [15:0] r_send;
  logic [15:0] r_recv;
  logic [15:0] r_err;
  logic [3:0]  r_out;

  logic        w_start_ok;
  logic        w_op_fire;
  logic        w_res_fire;
  logic        w_last_op;
  logic [16:0] w_mis;
  logic [16:0] w_err_sum;
  logic [15:0] w_err_next;

  assign w_start_ok = start && ((r_state == c_st_idle) || (r_state == c_st_done));
  // op_valid can only fall through an accept, so the offered beat holds until taken
  assign op_valid   = (r_state == c_st_run) && (r_send < r_num) && (r_out < c_max_out);
  assign res_ready  = (r_state == c_st_run) || (r_state == c_st_drain);
  assign busy       = res_ready;
  assign done       = (r_state == c_st_done);
  assign err_count  = r_err;
  assign w_op_fire  = op_valid && op_ready;
  assign w_res_fire = res_valid && res_ready;
  assign w_last_op  = w_op_fire && (r_send == (r_num - 16'd1));

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (op_valid) begin
      for (int i = 0; i < LANES; i++) begin
        op_a[32*i +: 32] = {16'd0, r_send} + 32'(i);
        op_b[32*i +: 32] = {16'd0, r_send} * 32'd3;
      end
    end
  end

  always_comb begin
    w_mis = '0;
    for (int i = 0; i < LANES; i++) begin
      if (res_y[32*i +: 32] != ({14'd0, r_recv, 2'b00} + 32'(i))) begin
        w_mis = w_mis + 17'd1;
      end
    end
    w_err_sum  = {1'b0, r_err} + w_mis;
    w_err_next = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_num   <= '0;
      r_send  <= '0;
      r_recv  <= '0;
      r_err   <= '0;
      r_out   <= '0;
    end else begin
      if (w_op_fire) begin
        r_send <= r_send + 16'd1;
      end
      if (w_res_fire) begin
        r_recv <= r_recv + 16'd1;
        r_err  <= w_err_next;
      end
      if (w_op_fire && !w_res_fire) begin
        r_out <= r_out + 4'd1;
      end else if (!w_op_fire && w_res_fire && (r_out != 4'd0)) begin
        r_out <= r_out - 4'd1;
      end

      case (r_state)
        c_st_idle, c_st_done: begin
          if (w_start_ok) begin
            r_num   <= num;
            r_send  <= '0;
            r_recv  <= '0;
            r_err   <= '0;
            r_out   <= '0;
            r_state <= (num != 16'd0) ? c_st_run : c_st_done;
          end
        end
        c_st_run: begin
          if (w_last_op) begin
            r_state <= c_st_drain;
          end
        end
        c_st_drain: begin
          if (r_out == 4'd0) begin
            r_state <= c_st_done;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

`ifdef ADD_DRIVER_CYCLE_COUNT_EN
  logic [31:0] r_cycles;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycles <= '0;
    end else if (w_start_ok) begin
      r_cycles <= '0;
    end else if (busy) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign cycles = r_cycles;
`else
  assign cycles = '0;
`endif

endmodule
`default_nettype wire

// File: doc/add_driver.md
ADD_DRIVER -- requirements
Module: add_driver

Interface
REQ-001 SHALL have parameter LANES, default 1, giving the number of 32-bit lanes per beat.
REQ-002 SHALL have parameter MAX_OUT, default 4, giving the maximum number of sent-but-unreturned transactions (range 1..15).
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that launches a run; it is ignored unless the block is in IDLE or DONE.
REQ-006 SHALL have port num, input, 16, the transaction count, sampled on the start cycle.
REQ-007 SHALL have port op_valid, output, 1, meaning an operand beat is offered.
REQ-008 SHALL have port op_ready, input, 1, meaning the adder accepts the operand beat.
REQ-009 SHALL have ports op_a and op_b, output, 32*LANES each, carrying the operand lanes; lane i occupies bits [32*i+:32].
REQ-010 SHALL have port res_valid, input, 1, meaning a result beat is offered.
REQ-011 SHALL have port res_ready, output, 1, meaning the result beat is accepted.
REQ-012 SHALL have port res_y, input, 32*LANES, carrying the result lanes.
REQ-013 SHALL have port busy, output, 1, high in RUN or DRAIN.
REQ-014 SHALL have port done, output, 1, high in DONE.
REQ-015 SHALL have port err_count, output, 16, the saturating count of mismatching lanes.
REQ-016 SHALL have port cycles, output, 32, giving the run length in cycles (see Configuration).

Function
REQ-017 SHALL implement an FSM with states IDLE, RUN, DRAIN and DONE.
- IDLE/DONE to RUN: on start with num != 0.
- IDLE/DONE to DONE: on start with num == 0.
- RUN to DRAIN: when the last operand beat is accepted.
- DRAIN to DONE: when outstanding count == 0.
REQ-018 SHALL define a beat as transferred only in a cycle with valid && ready high.
- Once op_valid is asserted, op_valid, op_a and op_b SHALL hold until accepted.
REQ-019 SHALL drive the operands of transaction k (0-based send counter) as: lane i op_a = k+i, op_b = 3*k, all mod 2^32.
REQ-020 SHALL assert op_valid in RUN only while send count < num and outstanding count < MAX_OUT.
REQ-021 SHALL assert res_ready in RUN and DRAIN only.
- Results arrive in order; receive counter r indexes them.
- Expected lane i value = 4*r+i mod 2^32.
REQ-022 SHALL increment err_count by the number of mismatching lanes in each accepted result beat, saturating at 0xFFFF.
REQ-023 SHALL maintain the outstanding count as +1 per accepted operand and -1 per accepted result.
- Both in the same cycle: count unchanged.
- It SHALL never exceed MAX_OUT.
REQ-024 SHALL keep err_count stable after DONE until the next start.
- A new accepted start clears err_count and the send and receive counters.
REQ-025 SHALL ignore any result beat offered in IDLE or DONE: res_ready is low and counters do not change.

Reset
REQ-026 SHALL enter the following state on reset, asynchronously:
- FSM to IDLE.
- op_valid, res_ready, busy, done = 0.
- op_a, op_b, err_count, cycles, all counters = 0.
REQ-027 SHALL abort a run when reset is asserted mid-run, with no further beats after reset deassertion until the next start.

Configuration
REQ-028 SHALL have the cycle counter controlled by macro ADD_DRIVER_CYCLE_COUNT_EN.
- When defined: cycles counts clock edges spent in RUN and DRAIN, wraps at 2^32, holds in DONE and clears on an accepted start.
- When undefined: cycles is tied to 0 and no counter register is built.

Verification
REQ-029 SHALL pass this case: LANES=1, num=3, op_ready and a loopback adder always ready, res_y = a+b after 1 cycle -> beats (0,0),(1,3),(2,6), done high, err_count=0.
REQ-030 SHALL pass this case: LANES=2, num=1, result lane1 forced to 0 -> err_count=1, done high.
REQ-031 SHALL pass this case: MAX_OUT=2, num=5, res_valid held low -> exactly 2 operands accepted, then op_valid stays low, busy=1.
REQ-032 SHALL pass this case: op_ready low for 4 cycles after op_valid rises -> op_a/op_b stable throughout, a single transfer occurs.
REQ-033 SHALL pass this case: start with num=0 -> done on the next cycle, no op_valid, and cycles=0.
REQ-034 SHALL pass this case: reset asserted mid-DRAIN -> all outputs are 0 immediately, and a later start with num=2 runs cleanly with err_count=0.
